// File: rtl/adc_spi_reader.sv
// ---------------------------------------------------------------------------
// adc_spi_reader
//   SPI master for a 12-bit, 8-channel serial ADC (ADC128S022-style framing).
//   A free-running sample timer starts one conversion every SAMPLE_DIV clocks.
//   Each conversion is a 16-bit SCLK frame. The frame sends the channel address
//   and reads back a 12-bit sample, which is then published on d_signal.
//
//   Optional feature macro: ADC_AVG_EN
//     defined   : d_signal is the mean of the last 4 raw samples
//                 (14-bit sum, truncating >>2)
//     undefined : d_signal is the raw sample
//
// Ports
//   clk          in   1   system clock
//   rst          in   1   synchronous, active-high reset
//   adc_cs_n     out  1   ADC chip select, active low
//   adc_sclk     out  1   SPI clock, idles high, registered
//   adc_din      out  1   MOSI (ADD2..ADD0 during bits 3..5, else 0)
//   adc_dout     in   1   MISO from ADC
//   d_signal     out  12  last published sample, unsigned, held between strobes
//   sample_valid out  1   1-cycle strobe, high in the cycle d_signal updates
//   busy         out  1   high while adc_cs_n is low
//
// Handshake: sample_valid is a valid-only strobe with no ready. A consumer must
// take d_signal in the strobe cycle or later; the value holds until the next
// strobe.
// ---------------------------------------------------------------------------
module adc_spi_reader #(
    parameter int         CLK_HZ    = 25000000,
    parameter int         SCLK_HZ   = 3125000,
    parameter int         SAMPLE_HZ = 100000,
    parameter logic [2:0] CHANNEL   = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_din,
    input  logic        adc_dout,
    output logic [11:0] d_signal,
    output logic        sample_valid,
    output logic        busy
);

    localparam int HALF_RAW   = CLK_HZ / (2 * SCLK_HZ);
    localparam int HALF       = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int SAMPLE_DIV = CLK_HZ / SAMPLE_HZ;
    localparam int PH_W       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int TM_W       = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF - 1);
    localparam logic [TM_W-1:0] TM_LAST = TM_W'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [TM_W-1:0] r_timer;
    logic [PH_W-1:0] r_phase_cnt;
    // SHIFT has 32 half-periods. Even index = low phase and odd index = high
    // phase of bit (index/2 + 1).
    logic [4:0]      r_phase_idx;

    logic            r_cs_n;
    logic            r_sclk;
    logic            r_din;
    logic [11:0]     r_shift;
    logic [11:0]     r_d_signal;
    logic            r_valid;

    logic            w_trigger;
    logic            w_phase_end;
    logic            w_last_phase;
    logic            w_start;
    logic            w_sclk_fall;
    logic            w_sclk_rise;
    logic            w_capture;
    logic            w_publish;
    logic [4:0]      w_fall_bit;
    logic            w_din_next;
    logic [11:0]     w_sample_out;

    // ---------------- sample timer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else if (r_timer == TM_LAST) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    assign w_trigger    = (r_timer == '0);
    assign w_phase_end  = (r_phase_cnt == PH_LAST);
    assign w_last_phase = (r_phase_idx == 5'd31);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_trigger) w_next_state = ST_SETUP;
            ST_SETUP: if (w_phase_end) w_next_state = ST_SHIFT;
            ST_SHIFT: if (w_phase_end && w_last_phase) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // ---------------- FSM: output decode ----------------
    // The strobes below act on the clock edge that leaves the current phase.
    // All pins are therefore registered, and they change exactly on phase
    // boundaries.
    always_comb begin
        w_start     = 1'b0;
        w_sclk_fall = 1'b0;
        w_sclk_rise = 1'b0;
        w_capture   = 1'b0;
        w_publish   = 1'b0;
        w_fall_bit  = 5'd0;
        case (r_state)
            ST_IDLE: begin
                w_start = w_trigger;
            end
            ST_SETUP: begin
                w_sclk_fall = w_phase_end;
                w_fall_bit  = 5'd1;
            end
            ST_SHIFT: begin
                // Falling edge k+1 follows the high phase of bit k. The last
                // high phase ends the frame instead of falling again.
                w_sclk_fall = w_phase_end && r_phase_idx[0] && !w_last_phase;
                w_fall_bit  = {1'b0, r_phase_idx[4:1]} + 5'd2;
                w_sclk_rise = w_phase_end && !r_phase_idx[0];
                // Bits 1..4 are leading zeros; capture only bits 5..16.
                w_capture   = w_sclk_rise && (r_phase_idx[4:1] >= 4'd4);
                w_publish   = w_phase_end && w_last_phase;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        w_din_next = 1'b0;
        case (w_fall_bit)
            5'd3:    w_din_next = CHANNEL[2];
            5'd4:    w_din_next = CHANNEL[1];
            5'd5:    w_din_next = CHANNEL[0];
            default: w_din_next = 1'b0;
        endcase
    end

    // ---------------- phase counters ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase_cnt <= '0;
            r_phase_idx <= '0;
        end else if (r_state == ST_SETUP || r_state == ST_SHIFT) begin
            if (w_phase_end) begin
                r_phase_cnt <= '0;
                r_phase_idx <= (r_state == ST_SHIFT) ? r_phase_idx + 5'd1 : 5'd0;
            end else begin
                r_phase_cnt <= r_phase_cnt + 1'b1;
            end
        end else begin
            r_phase_cnt <= '0;
            r_phase_idx <= '0;
        end
    end

    // ---------------- pins and data path ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_n     <= 1'b1;
            r_sclk     <= 1'b1;
            r_din      <= 1'b0;
            r_shift    <= '0;
            r_d_signal <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= w_publish;
            if (w_start) begin
                r_cs_n <= 1'b0;
            end else if (w_publish) begin
                r_cs_n <= 1'b1;
            end
            if (w_sclk_fall) begin
                r_sclk <= 1'b0;
                r_din  <= w_din_next;
            end else if (w_sclk_rise) begin
                r_sclk <= 1'b1;
            end
            // adc_dout is sampled on the edge that raises SCLK. The ADC drove
            // it a full low phase earlier.
            if (w_capture) begin
                r_shift <= {r_shift[10:0], adc_dout};
            end
            // The result is loaded on the edge that enters DONE. d_signal and
            // sample_valid therefore appear together in the DONE cycle, which
            // is also the first cycle with cs_n high again.
            if (w_publish) begin
                r_d_signal <= w_sample_out;
            end
        end
    end

`ifdef ADC_AVG_EN
    // r_hist0 is the newest stored sample. The incoming r_shift is the fourth
    // term of the average.
    logic [11:0] r_hist0;
    logic [11:0] r_hist1;
    logic [11:0] r_hist2;
    logic [13:0] w_sum;

    assign w_sum = {2'b00, r_shift} + {2'b00, r_hist0}
                 + {2'b00, r_hist1} + {2'b00, r_hist2};
    assign w_sample_out = w_sum[13:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist0 <= '0;
            r_hist1 <= '0;
            r_hist2 <= '0;
        end else if (w_publish) begin
            r_hist2 <= r_hist1;
            r_hist1 <= r_hist0;
            r_hist0 <= r_shift;
        end
    end
`else
    assign w_sample_out = r_shift;
`endif

    assign adc_cs_n     = r_cs_n;
    assign adc_sclk     = r_sclk;
    assign adc_din      = r_din;
    assign d_signal     = r_d_signal;
    assign sample_valid = r_valid;
    assign busy         = ~r_cs_n;

endmodule

// File: tb/tb_adc_spi_reader.sv
// ---------------------------------------------------------------------------
// tb_adc_spi_reader
//   Bench for adc_spi_reader. It uses default rates (HALF=4, SAMPLE_DIV=250)
//   and CHANNEL=5.
//   An ADC model drives adc_dout after each SCLK fall. It sends random
//   leading bits, then D11..D0 of the word queued for that frame. The monitor
//   checks the frame shape and the channel bits. It also compares every
//   published sample with a reference model: the raw word, or the mean of the
//   last four words when ADC_AVG_EN is defined.
// ---------------------------------------------------------------------------
module tb_adc_spi_reader;

  localparam int N_VEC = 6;

  typedef struct {
    logic [11:0] word;
    logic [11:0] exp_d;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_din;
  logic        adc_dout;
  logic [11:0] d_signal;
  logic        sample_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // ADC model and scoreboard state
  logic [11:0] adc_q[$];   // words the ADC model returns, one per frame
  logic [11:0] exp_q[$];   // raw words of frames in flight
  logic [11:0] cur_word;
  logic [15:0] din_word;
  int          hist[4];
  int          cs_len, falls, rises;
  int          din_viol = 0;
  int          busy_viol = 0;
  bit          in_conv = 0;
  logic        prev_cs_n = 1'b1;
  logic        prev_sclk = 1'b1;
  logic        prev_din = 1'b0;
  logic        prev_valid = 1'b0;

  vec_t tbl[N_VEC];

  adc_spi_reader #(
    .CLK_HZ   (25000000),
    .SCLK_HZ  (3125000),
    .SAMPLE_HZ(100000),
    .CHANNEL  (3'd5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .adc_cs_n    (adc_cs_n),
    .adc_sclk    (adc_sclk),
    .adc_din     (adc_din),
    .adc_dout    (adc_dout),
    .d_signal    (d_signal),
    .sample_valid(sample_valid),
    .busy        (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: the value a consumer should see for a newly converted word.
  function automatic int model_publish(input int raw);
    int acc;
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = raw;
`ifdef ADC_AVG_EN
    acc = hist[0] + hist[1] + hist[2] + hist[3];
    return acc / 4;
`else
    acc = raw;
    return acc;
`endif
  endfunction

  // ---------------- ADC model, monitor and scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 4; i++) hist[i] = 0;
      in_conv  = 0;
      adc_dout = 1'b0;
    end else begin
      if (prev_cs_n && !adc_cs_n) begin
        in_conv  = 1;
        cs_len   = 0;
        falls    = 0;
        rises    = 0;
        din_word = '0;
        if (adc_q.size() > 0) cur_word = adc_q.pop_front();
        else cur_word = 12'($urandom_range(0, 4095));
        exp_q.push_back(cur_word);
      end
      if (!adc_cs_n) cs_len++;
      if (!adc_cs_n && prev_sclk && !adc_sclk) begin
        falls++;
        if (falls <= 4) adc_dout = 1'($urandom_range(0, 1));
        else if (falls <= 16) adc_dout = cur_word[16 - falls];
      end
      if (!adc_cs_n && !prev_sclk && adc_sclk) begin
        rises++;
        if (rises <= 16) din_word[rises - 1] = adc_din;
      end
      if (adc_din != prev_din && !(prev_sclk && !adc_sclk)) din_viol++;
      if (busy != !adc_cs_n) busy_viol++;
      if (in_conv && !prev_cs_n && adc_cs_n) begin
        in_conv = 0;
        check("cs_low_cycles", cs_len, 132);
        check("sclk_falls", falls, 16);
        check("sclk_rises", rises, 16);
        check("din_bits_ch5", din_word, 16'h0014);
        check("valid_at_cs_rise", sample_valid, 1);
      end
      if (sample_valid) begin
        check("valid_one_cycle", prev_valid, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid actual=1 expected=0");
        end else begin
          check("model_d_signal", d_signal, model_publish(exp_q.pop_front()));
        end
      end
    end
    prev_cs_n  = adc_cs_n;
    prev_sclk  = adc_sclk;
    prev_din   = adc_din;
    prev_valid = sample_valid;
  end

  // ---------------- drivers ----------------
  task automatic wait_valid(output int n, output bit ok);
    n  = 0;
    ok = 0;
    while (!ok && n < 400) begin
      @(negedge clk);
      n++;
      if (sample_valid) ok = 1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"}, adc_cs_n, 1);
    check({tag, "_sclk"}, adc_sclk, 1);
    check({tag, "_din"}, adc_din, 0);
    check({tag, "_d_signal"}, d_signal, 0);
    check({tag, "_valid"}, sample_valid, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bit ok;
    int t;
    logic [11:0] exp_after_rst;

`ifdef ADC_AVG_EN
    tbl[0] = '{12'd100, 12'd25};
    tbl[1] = '{12'd200, 12'd75};
    tbl[2] = '{12'd300, 12'd150};
    tbl[3] = '{12'd400, 12'd250};
    tbl[4] = '{12'd400, 12'd325};
    tbl[5] = '{12'd0,   12'd275};
    exp_after_rst = 12'h0F1;   // 0x3C5 averaged with three zeros
`else
    tbl[0] = '{12'hABC, 12'hABC};
    tbl[1] = '{12'h000, 12'h000};
    tbl[2] = '{12'hFFF, 12'hFFF};
    tbl[3] = '{12'h5A5, 12'h5A5};
    tbl[4] = '{12'h801, 12'h801};
    tbl[5] = '{12'h7FE, 12'h7FE};
    exp_after_rst = 12'h3C5;
`endif

    rst = 1'b1;
    for (int i = 0; i < N_VEC; i++) adc_q.push_back(tbl[i].word);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Release: the first frame starts on the next edge.
    rst = 1'b0;
    @(negedge clk);
    check("cs_n_first_cycle", adc_cs_n, 0);

    for (int i = 0; i < N_VEC; i++) begin
      wait_valid(n, ok);
      check("valid_seen", ok, 1);
      if (i == 0) check("first_valid_latency", n, 132);
      else check("valid_interval", n, 250);
      check("table_d_signal", d_signal, tbl[i].exp_d);
    end

    // Free-running random words, checked only by the reference model.
    for (int j = 0; j < 6; j++) begin
      wait_valid(n, ok);
      check("valid_seen_rand", ok, 1);
      check("valid_interval_rand", n, 250);
    end

    // Reset in the middle of a frame, after the 8th SCLK fall.
    t = 0;
    while (!(in_conv && falls >= 8) && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("reached_fall8", (in_conv && falls >= 8) ? 1 : 0, 1);
    rst = 1'b1;
    adc_q.push_back(12'h3C5);
    @(negedge clk);
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("cs_n_after_reset", adc_cs_n, 0);
    wait_valid(n, ok);
    check("valid_seen_after_reset", ok, 1);
    check("latency_after_reset", n, 132);
    check("d_signal_after_reset", d_signal, exp_after_rst);

    repeat (5) @(negedge clk);
    check("din_changes_only_on_fall", din_viol, 0);
    check("busy_matches_cs", busy_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
